// File: rtl/spi_rx.sv
// SPI receiver: oversamples spi_clk/spi_rx_data on RST_clk and deserializes MSB-first frames
// into a valid/ready holding register, with an idle timeout that discards partial frames.
module spi_rx #(
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2,
    parameter bit SAMPLE_EDGE  = 1'b0,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic                 RST_clk,
    input  logic                 RST_n,
    input  logic                 spi_clk,
    input  logic                 spi_rx_data,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_overrun,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [1:0]             rst_ff;
    logic                   rst;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_now;
    logic                   bit_in;
    logic                   strobe;
    state_t                 state;
    state_t                 state_nxt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [31:0]            tmo_cnt;
    logic                   last_bit;
    logic                   timeout_hit;
    logic                   frame_done;
    logic                   timeout_drop;
    logic                   byte_done;

    // NOTE: reset asserts asynchronously but releases only after two clean RST_clk edges,
    // so no downstream flop sees reset removal close to its active edge.
    always_ff @(posedge RST_clk or posedge RST_n) begin
        if (RST_n) rst_ff <= 2'b11;
        else       rst_ff <= {rst_ff[0], 1'b0};
    end
    assign rst = rst_ff[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge RST_clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '0;
            data_sync <= '1;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_rx_data};
            clk_prev  <= clk_now;
        end
    end

    assign clk_now     = clk_sync[SYNC_STAGES-1];
    assign bit_in      = data_sync[SYNC_STAGES-1];
    assign strobe      = SAMPLE_EDGE ? (clk_now & ~clk_prev) : (~clk_now & clk_prev);
    assign last_bit    = (bit_cnt == CNT_W'(DATA_BITS - 1));
    assign timeout_hit = (tmo_cnt == 32'(IDLE_TIMEOUT - 1));

    always_ff @(posedge RST_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (strobe && !last_bit) state_nxt = SHIFT;
            SHIFT: if ((strobe && last_bit) || (!strobe && timeout_hit)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_busy      = 1'b0;
        frame_done   = 1'b0;
        timeout_drop = 1'b0;
        case (state)
            IDLE:  frame_done = strobe && last_bit;
            SHIFT: begin
                rx_busy      = 1'b1;
                frame_done   = strobe && last_bit;
                timeout_drop = !strobe && timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge RST_clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            byte_done  <= 1'b0;
            frame_err  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            frame_err <= timeout_drop;
            byte_done <= frame_done;

            if (strobe) begin
                shift_reg <= {shift_reg[DATA_BITS-2:0], bit_in};
                bit_cnt   <= frame_done ? '0 : bit_cnt + 1'b1;
                tmo_cnt   <= '0;
            end else if (timeout_drop) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                tmo_cnt   <= '0;
            end else if (state == SHIFT) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            // A finished byte loads only if the holding register is free or draining this cycle.
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (byte_done) begin
                rx_overrun <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: falling-edge instance driven through all scenarios, plus a
// rising-edge instance; delivered bytes are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_spi_rx;

    localparam int HALF = 20;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       spi_clk    = 1'b0;
    logic       spi_data   = 1'b1;
    logic       rx_ready   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, rx_overrun, frame_err;

    logic       spi_clk_r  = 1'b0;
    logic       spi_data_r = 1'b1;
    logic       rx_ready_r = 1'b1;
    logic [7:0] rx_data_r;
    logic       rx_valid_r, rx_busy_r, rx_overrun_r, frame_err_r;

    int         n_assert     = 0;
    int         n_fail       = 0;
    int         valid_cycles = 0;
    int         fe_pulses    = 0;
    int         r_count      = 0;
    logic [7:0] r_last       = 8'h00;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;

    spi_rx #(.DATA_BITS(8), .SYNC_STAGES(2), .SAMPLE_EDGE(1'b0), .IDLE_TIMEOUT(200)) dut (
        .RST_clk(clk), .RST_n(rst), .spi_clk(spi_clk), .spi_rx_data(spi_data),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
        .rx_overrun(rx_overrun), .frame_err(frame_err)
    );

    spi_rx #(.DATA_BITS(8), .SYNC_STAGES(2), .SAMPLE_EDGE(1'b1), .IDLE_TIMEOUT(200)) dut_r (
        .RST_clk(clk), .RST_n(rst), .spi_clk(spi_clk_r), .spi_rx_data(spi_data_r),
        .rx_ready(rx_ready_r), .rx_data(rx_data_r), .rx_valid(rx_valid_r), .rx_busy(rx_busy_r),
        .rx_overrun(rx_overrun_r), .frame_err(frame_err_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data changes with the rising edge and is sampled on the falling edge.
    task automatic send(input logic [7:0] b, input int nbits, input bit chk_busy);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_data = b[i];
            spi_clk  = 1'b1;
            wait_cycles(HALF);
            spi_clk  = 1'b0;
            wait_cycles(HALF);
            if (chk_busy) check($sformatf("busy_after_bit%0d", 7 - i), 32'(rx_busy), 32'(i != 0));
        end
        spi_data = 1'b1;
    endtask

    // Data changes with the falling edge and is sampled on the rising edge.
    task automatic send_r(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_data_r = b[i];
            wait_cycles(HALF);
            spi_clk_r  = 1'b1;
            wait_cycles(HALF);
            spi_clk_r  = 1'b0;
        end
        spi_data_r = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rx_valid)  valid_cycles++;
        if (frame_err) fe_pulses++;
        if (rx_valid && rx_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (rx_valid_r) begin
            r_last = rx_data_r;
            r_count++;
        end
    end

    initial begin
        int v0, fe0;

        wait_cycles(3);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);
        check("rst_rx_overrun", 32'(rx_overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // Single byte with rx_ready held high
        v0 = valid_cycles;
        check("t1_busy_idle", 32'(rx_busy), 32'h0);
        exp_q.push_back(8'hA5);
        send(8'hA5, 8, 1'b1);
        check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("t1_frame_err", 32'(fe_pulses), 32'd0);
        check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames
        v0 = valid_cycles;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send(8'h3C, 8, 1'b0);
        send(8'hC3, 8, 1'b0);
        check("t2_valid_cycles", 32'(valid_cycles - v0), 32'd2);
        check("t2_overrun", 32'(rx_overrun), 32'h0);
        check("t2_sb_drained", 32'(exp_q.size()), 32'd0);

        // Consumer stalled: second byte dropped, overrun set
        rx_ready = 1'b0;
        exp_q.push_back(8'h12);
        send(8'h12, 8, 1'b0);
        check("t3_valid_first", 32'(rx_valid), 32'h1);
        check("t3_data_first", 32'(rx_data), 32'h12);
        check("t3_no_overrun_yet", 32'(rx_overrun), 32'h0);
        send(8'h34, 8, 1'b0);
        check("t3_valid_held", 32'(rx_valid), 32'h1);
        check("t3_data_held", 32'(rx_data), 32'h12);
        check("t3_overrun", 32'(rx_overrun), 32'h1);
        rx_ready = 1'b1;
        wait_cycles(1);
        check("t3_valid_drop", 32'(rx_valid), 32'h0);
        check("t3_data_after", 32'(rx_data), 32'h12);
        check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

        // Partial frame abandoned by timeout
        fe0 = fe_pulses;
        send(8'hFF, 5, 1'b0);
        check("t4_busy_partial", 32'(rx_busy), 32'h1);
        v0 = valid_cycles;
        wait_cycles(400);
        check("t4_frame_err_pulses", 32'(fe_pulses - fe0), 32'd1);
        check("t4_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("t4_busy_cleared", 32'(rx_busy), 32'h0);
        check("t4_overrun_sticky", 32'(rx_overrun), 32'h1);
        exp_q.push_back(8'h81);
        send(8'h81, 8, 1'b0);
        check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame
        fe0 = fe_pulses;
        send(8'h5A, 4, 1'b0);
        check("t5_busy_before_rst", 32'(rx_busy), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(rx_busy), 32'h0);
        check("t5_rst_overrun", 32'(rx_overrun), 32'h0);
        check("t5_rst_data", 32'(rx_data), 32'h0);
        check("t5_rst_valid", 32'(rx_valid), 32'h0);
        wait_cycles(3);
        check("t5_rst_held_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        wait_cycles(5);
        exp_q.push_back(8'h5A);
        send(8'h5A, 8, 1'b0);
        check("t5_sb_drained", 32'(exp_q.size()), 32'd0);
        check("t5_no_frame_err", 32'(fe_pulses - fe0), 32'd0);

        // Rising-edge sampling instance
        send_r(8'hF0);
        wait_cycles(5);
        check("t6_rise_data", 32'(r_last), 32'hF0);
        check("t6_rise_count", 32'(r_count), 32'd1);
        check("t6_rise_overrun", 32'(rx_overrun_r), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
